channel_quadrature_decoder: RTL and testbench

Parametrised quadrature encoder input channel for the advanced timer pattern-engine core. It filters A/B/Z encoder inputs and decodes their Gray-code transitions with a state machine, counting at x1/x2/x4 resolution with per-transition direction. The counter is width-generic, supports index (Z) reset, and flags illegal transitions and wrap. On each timer period end it captures the count into a readable register; an event landing on that boundary is not lost.

---
 rtl/channel_quadrature_decoder.sv | 148 ++++++++++++++
 tb/tb_channel_quadrature_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_quadrature_decoder.sv
// channel_quadrature_decoder
// Quadrature encoder input channel: polarity, per-input glitch filter,
// Gray-code decoder with x1/x2/x4 resolution, index (Z) reset, and a
// period-end capture register.
//
// Ports:
//   pe_enc_clk, pe_enc_rstn      clock, async active-low reset
//   pe_enc_logic_clr             synchronous clear; config may change only here
//   timing_enable                gates counting (direction still tracks)
//   arr_cnt_end                  period end: capture count and restart
//   r_ecm, r_ecp, r_ecnp, r_ecf, r_eczen   mode / polarity / filter / index cfg
//   ec_a, ec_b, ec_z             synchronised encoder inputs
//   r_ec                         captured count
//   r_ed                         direction (0 forward, 1 reverse)
//   r_eerr, r_eovf               sticky illegal-transition / wrap flags
//   encoder_detected             combinational counting-event strobe
module channel_quadrature_decoder #(
  parameter int CNT_W = 16,
  parameter int FLT_W = 4
) (
  input  logic             pe_enc_clk,
  input  logic             pe_enc_rstn,
  input  logic             pe_enc_logic_clr,
  input  logic             timing_enable,
  input  logic             arr_cnt_end,
  input  logic [1:0]       r_ecm,
  input  logic             r_ecp,
  input  logic             r_ecnp,
  input  logic [FLT_W-1:0] r_ecf,
  input  logic             r_eczen,
  input  logic             ec_a,
  input  logic             ec_b,
  input  logic             ec_z,
  output logic [CNT_W-1:0] r_ec,
  output logic             r_ed,
  output logic             r_eerr,
  output logic             r_eovf,
  output logic             encoder_detected
);

  // Bit 2 = A, bit 1 = B, bit 0 = Z. Z is never inverted.
  logic [2:0]       raw;
  logic [2:0]       filt;
  logic [FLT_W-1:0] fcnt [3];

  logic [1:0]       s;
  logic [1:0]       s_d;
  logic             z_d;
  logic [CNT_W-1:0] cnt;

  logic             chg;
  logic             illegal;
  logic             legal_chg;
  logic             fwd;
  logic             qual;
  logic             z_rise;

  assign raw = {ec_a ^ r_ecp, ec_b ^ r_ecnp, ec_z};
  assign s   = filt[2:1];

  always_comb begin
    chg       = (s != s_d);
    illegal   = ((s ^ s_d) == 2'b11);
    legal_chg = chg && !illegal;
    // Forward order 00->10->11->01->00; any other single-bit change is reverse.
    fwd       = ((s_d == 2'b00) && (s == 2'b10)) ||
                ((s_d == 2'b10) && (s == 2'b11)) ||
                ((s_d == 2'b11) && (s == 2'b01)) ||
                ((s_d == 2'b01) && (s == 2'b00));
    unique case (r_ecm)
      2'b00:   qual = legal_chg &&
                      (((s_d == 2'b00) && (s == 2'b10)) ||
                       ((s_d == 2'b10) && (s == 2'b00)));
      2'b01:   qual = legal_chg && (s[1] != s_d[1]);
      default: qual = legal_chg;
    endcase
    z_rise           = filt[0] && !z_d;
    encoder_detected = timing_enable && qual;
  end

  always_ff @(posedge pe_enc_clk or negedge pe_enc_rstn) begin
    if (!pe_enc_rstn) begin
      filt   <= '0;
      for (int unsigned i = 0; i < 3; i++) fcnt[i] <= '0;
      s_d    <= '0;
      z_d    <= 1'b0;
      cnt    <= '0;
      r_ec   <= '0;
      r_ed   <= 1'b0;
      r_eerr <= 1'b0;
      r_eovf <= 1'b0;
    end else if (pe_enc_logic_clr) begin
      // Load filtered and history state from the live inputs so leaving
      // clear never produces a spurious transition.
      filt   <= raw;
      for (int unsigned i = 0; i < 3; i++) fcnt[i] <= '0;
      s_d    <= raw[2:1];
      z_d    <= raw[0];
      cnt    <= '0;
      r_ec   <= '0;
      r_ed   <= 1'b0;
      r_eerr <= 1'b0;
      r_eovf <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == r_ecf) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FLT_W'(1);
        end
      end
      s_d <= s;
      z_d <= filt[0];

      if (illegal)   r_eerr <= 1'b1;
      if (legal_chg) r_ed   <= !fwd;

      if (arr_cnt_end) begin
        // Restart from zero, but keep an event that lands on the boundary.
        r_ec <= cnt;
        if (encoder_detected) begin
          if (fwd) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt    <= '1;
            r_eovf <= 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end else if (r_eczen && z_rise) begin
        cnt <= '0;
      end else if (encoder_detected) begin
        if (fwd) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1) r_eovf <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) r_eovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_quadrature_decoder.sv
// Directed self-checking bench for channel_quadrature_decoder (CNT_W=16).
// Inputs change right after a falling edge; outputs are sampled on falling
// edges. The internal count is observed through arr_cnt_end captures.
module tb_channel_quadrature_decoder;

  logic        pe_enc_clk = 1'b0;
  logic        pe_enc_rstn;
  logic        pe_enc_logic_clr;
  logic        timing_enable;
  logic        arr_cnt_end;
  logic [1:0]  r_ecm;
  logic        r_ecp;
  logic        r_ecnp;
  logic [3:0]  r_ecf;
  logic        r_eczen;
  logic        ec_a;
  logic        ec_b;
  logic        ec_z;
  logic [15:0] r_ec;
  logic        r_ed;
  logic        r_eerr;
  logic        r_eovf;
  logic        encoder_detected;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulses    = 0;

  channel_quadrature_decoder #(.CNT_W(16), .FLT_W(4)) dut (
    .pe_enc_clk       (pe_enc_clk),
    .pe_enc_rstn      (pe_enc_rstn),
    .pe_enc_logic_clr (pe_enc_logic_clr),
    .timing_enable    (timing_enable),
    .arr_cnt_end      (arr_cnt_end),
    .r_ecm            (r_ecm),
    .r_ecp            (r_ecp),
    .r_ecnp           (r_ecnp),
    .r_ecf            (r_ecf),
    .r_eczen          (r_eczen),
    .ec_a             (ec_a),
    .ec_b             (ec_b),
    .ec_z             (ec_z),
    .r_ec             (r_ec),
    .r_ed             (r_ed),
    .r_eerr           (r_eerr),
    .r_eovf           (r_eovf),
    .encoder_detected (encoder_detected)
  );

  always #5 pe_enc_clk = ~pe_enc_clk;

  // All stimulus tasks start and end just after a falling edge.
  task automatic configure(input logic [1:0] mode, input logic [3:0] ecf,
                           input logic zen);
    r_ecm = mode; r_ecf = ecf; r_eczen = zen;
    pe_enc_logic_clr = 1'b1;
    @(negedge pe_enc_clk);
    pe_enc_logic_clr = 1'b0;
  endtask

  task automatic step(input logic a, input logic b);
    ec_a = a; ec_b = b;
    for (int i = 0; i < 4; i++) begin
      @(negedge pe_enc_clk);
      if (encoder_detected) pulses++;
    end
  endtask

  task automatic fwd_cycle();
    step(1, 0); step(1, 1); step(0, 1); step(0, 0);
  endtask

  task automatic rev_cycle();
    step(0, 1); step(1, 1); step(1, 0); step(0, 0);
  endtask

  task automatic capture();
    arr_cnt_end = 1'b1;
    @(negedge pe_enc_clk);
    arr_cnt_end = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({r_ec, r_ed, r_eerr, r_eovf, encoder_detected} !== 20'h0) begin
      $display("FAIL reset_outputs: got %h, want 00000",
               {r_ec, r_ed, r_eerr, r_eovf, encoder_detected});
    end else pass_cnt++;
    @(negedge pe_enc_clk);
    pe_enc_rstn = 1'b1;
    @(negedge pe_enc_clk);
  endtask

  task automatic test_x4_forward_reverse();
    configure(2'b10, 4'd0, 1'b0);
    pulses = 0;
    fwd_cycle();
    total_cnt++;
    if (pulses !== 4) $display("FAIL x4_fwd_pulses: got %0d, want 4", pulses);
    else pass_cnt++;
    total_cnt++;
    if (r_ed !== 1'b0) $display("FAIL x4_fwd_dir: got %b, want 0", r_ed);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'd4) $display("FAIL x4_fwd_count: got %h, want 0004", r_ec);
    else pass_cnt++;
    total_cnt++;
    if (r_eovf !== 1'b0) $display("FAIL x4_fwd_ovf: got %b, want 0", r_eovf);
    else pass_cnt++;
    pulses = 0;
    rev_cycle();
    total_cnt++;
    if (r_ed !== 1'b1) $display("FAIL x4_rev_dir: got %b, want 1", r_ed);
    else pass_cnt++;
    total_cnt++;
    if (r_eovf !== 1'b1) $display("FAIL x4_rev_ovf: got %b, want 1", r_eovf);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'hFFFC) $display("FAIL x4_rev_count: got %h, want fffc", r_ec);
    else pass_cnt++;
  endtask

  task automatic test_resolution(input logic [1:0] mode, input logic [15:0] exp_two,
                                 input logic [15:0] exp_net);
    configure(mode, 4'd0, 1'b0);
    fwd_cycle(); fwd_cycle();
    capture();
    total_cnt++;
    if (r_ec !== exp_two)
      $display("FAIL res_m%0d_two_fwd: got %h, want %h", mode, r_ec, exp_two);
    else pass_cnt++;
    fwd_cycle(); fwd_cycle(); rev_cycle();
    capture();
    total_cnt++;
    if (r_ec !== exp_net)
      $display("FAIL res_m%0d_fwd_rev: got %h, want %h", mode, r_ec, exp_net);
    else pass_cnt++;
  endtask

  task automatic test_filter();
    logic [3:0] hist;
    configure(2'b10, 4'd3, 1'b0);
    pulses = 0;
    ec_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pe_enc_clk);
      if (encoder_detected) pulses++;
    end
    ec_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pe_enc_clk);
      if (encoder_detected) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL flt_glitch_pulses: got %0d, want 0", pulses);
    else pass_cnt++;
    ec_a = 1'b1;
    hist = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pe_enc_clk);
      hist[i] = encoder_detected;
    end
    total_cnt++;
    if (hist !== 4'b1000) $display("FAIL flt_detect_edge: got %b, want 1000", hist);
    else pass_cnt++;
    // Capture on the edge that applies the event: old count out, event kept.
    capture();
    total_cnt++;
    if (r_ec !== 16'd0) $display("FAIL flt_pre_update: got %h, want 0000", r_ec);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'd1) $display("FAIL flt_boundary_keep: got %h, want 0001", r_ec);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    configure(2'b10, 4'd0, 1'b0);
    step(0, 1);
    pulses = 0;
    step(1, 0);
    total_cnt++;
    if (r_eerr !== 1'b1) $display("FAIL ill_err_set: got %b, want 1", r_eerr);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== 0) $display("FAIL ill_no_event: got %0d, want 0", pulses);
    else pass_cnt++;
    total_cnt++;
    if (r_ed !== 1'b1) $display("FAIL ill_dir_hold: got %b, want 1", r_ed);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'hFFFF) $display("FAIL ill_count: got %h, want ffff", r_ec);
    else pass_cnt++;
    step(1, 1);
    total_cnt++;
    if ({r_eerr, r_ed} !== 2'b10)
      $display("FAIL ill_sticky: got err,dir=%b, want 10", {r_eerr, r_ed});
    else pass_cnt++;
    configure(2'b10, 4'd0, 1'b0);
    total_cnt++;
    if ({r_eerr, r_eovf} !== 2'b00)
      $display("FAIL ill_clr: got err,ovf=%b, want 00", {r_eerr, r_eovf});
    else pass_cnt++;
  endtask

  task automatic test_priority();
    ec_a = 1'b0; ec_b = 1'b0; ec_z = 1'b0;
    configure(2'b10, 4'd0, 1'b1);
    fwd_cycle(); step(1, 0); step(1, 1); step(0, 1);
    ec_b = 1'b0; ec_z = 1'b1;
    @(negedge pe_enc_clk);
    total_cnt++;
    if (encoder_detected !== 1'b1)
      $display("FAIL prio_detect: got %b, want 1", encoder_detected);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'd7) $display("FAIL prio_capture: got %h, want 0007", r_ec);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'd1) $display("FAIL prio_after: got %h, want 0001", r_ec);
    else pass_cnt++;
    // Index alone: count 2, Z rise clears, then one more forward step.
    ec_z = 1'b0;
    capture();
    step(1, 0); step(1, 1);
    ec_z = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge pe_enc_clk);
    step(0, 1);
    capture();
    total_cnt++;
    if (r_ec !== 16'd1) $display("FAIL index_clear: got %h, want 0001", r_ec);
    else pass_cnt++;
    ec_z = 1'b0;
    ec_a = 1'b0; ec_b = 1'b0;
    configure(2'b10, 4'd0, 1'b0);
    fwd_cycle(); step(1, 0); step(1, 1); step(0, 1);
    capture();
    total_cnt++;
    if (r_ec !== 16'd7) $display("FAIL end_alone_cap: got %h, want 0007", r_ec);
    else pass_cnt++;
    capture();
    total_cnt++;
    if (r_ec !== 16'd0) $display("FAIL end_alone_restart: got %h, want 0000", r_ec);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    ec_a = 1'b0; ec_b = 1'b0;
    configure(2'b10, 4'd0, 1'b0);
    timing_enable = 1'b0;
    pulses = 0;
    step(0, 1);
    total_cnt++;
    if ({pulses != 0, r_ed} !== 2'b01)
      $display("FAIL en_off: got pulses=%0d dir=%b, want 0/1", pulses, r_ed);
    else pass_cnt++;
    capture();
    total_cnt++;
    if ({r_ec, r_eovf} !== 17'h0)
      $display("FAIL en_off_count: got %h ovf=%b, want 0000/0", r_ec, r_eovf);
    else pass_cnt++;
    timing_enable = 1'b1;
  endtask

  task automatic test_async_reset();
    ec_a = 1'b0; ec_b = 1'b0;
    configure(2'b10, 4'd0, 1'b0);
    step(1, 0); step(1, 1);
    capture();
    step(1, 0);
    total_cnt++;
    if ({r_ec, r_ed} !== {16'd2, 1'b1})
      $display("FAIL arst_pre: got %h/%b, want 0002/1", r_ec, r_ed);
    else pass_cnt++;
    #2 pe_enc_rstn = 1'b0;
    #1;
    total_cnt++;
    if ({r_ec, r_ed} !== 17'h0)
      $display("FAIL arst_immediate: got %h/%b, want 0000/0", r_ec, r_ed);
    else pass_cnt++;
    @(negedge pe_enc_clk);
    @(negedge pe_enc_clk);
    pe_enc_rstn = 1'b1;
    // Inputs still 10: decoded against S_d = 00 as a forward step.
    @(negedge pe_enc_clk);
    total_cnt++;
    if (encoder_detected !== 1'b1)
      $display("FAIL arst_first_event: got %b, want 1", encoder_detected);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) @(negedge pe_enc_clk);
    capture();
    total_cnt++;
    if ({r_ec, r_ed} !== {16'd1, 1'b0})
      $display("FAIL arst_after: got %h/%b, want 0001/0", r_ec, r_ed);
    else pass_cnt++;
  endtask

  initial begin
    pe_enc_rstn = 1'b0; pe_enc_logic_clr = 1'b0; timing_enable = 1'b1;
    arr_cnt_end = 1'b0; r_ecm = 2'b10; r_ecp = 1'b0; r_ecnp = 1'b0;
    r_ecf = 4'd0; r_eczen = 1'b0; ec_a = 1'b0; ec_b = 1'b0; ec_z = 1'b0;
    @(negedge pe_enc_clk);
    test_reset();
    test_x4_forward_reverse();
    test_resolution(2'b00, 16'd2, 16'd1);
    test_resolution(2'b01, 16'd4, 16'd2);
    test_filter();
    ec_a = 1'b0; ec_b = 1'b0;
    test_illegal();
    test_priority();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
